// File: rtl/pong_pkg.sv
// Shared types and defaults for the paddle bank.
package pong_pkg;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_SLOW = 2'd1,
        P_FAST = 2'd2
    } paddle_state_t;

    localparam int POS_W_DEF = 10;

endpackage

// File: rtl/pong_paddle_channel.sv
// One paddle: accelerate FSM, hold counter, saturating position and pixel-hit compare.
import pong_pkg::*;

module pong_paddle_channel #(
    parameter int POS_W         = POS_W_DEF,
    parameter int PADDLE_HEIGHT = 48,
    parameter int PADDLE_WIDTH  = 8,
    parameter int MAX_POS       = 432,
    parameter int CENTRE        = 216,
    parameter int X_POS         = 16,
    parameter int STEP_SLOW     = 1,
    parameter int STEP_FAST     = 4,
    parameter int HOLD_TICKS    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic             recenter,
    input  logic             up,
    input  logic             down,
    input  logic [POS_W-1:0] hori,
    input  logic [POS_W-1:0] vert,
    output logic [POS_W-1:0] height,
    output logic             hit,
    output logic             on
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [POS_W:0] MAX_E  = (POS_W+1)'(MAX_POS);
    localparam logic [POS_W:0] X_LO   = (POS_W+1)'(X_POS);
    localparam logic [POS_W:0] X_HI   = (POS_W+1)'(X_POS + PADDLE_WIDTH);
    localparam logic [POS_W:0] PH_E   = (POS_W+1)'(PADDLE_HEIGHT);
    localparam logic [POS_W:0] SLOW_E = (POS_W+1)'(STEP_SLOW);
    localparam logic [POS_W:0] FAST_E = (POS_W+1)'(STEP_FAST);

    paddle_state_t   state;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_inc;
    logic            dir_q;
    logic            valid;
    logic [POS_W:0]  pos_e;
    logic [POS_W:0]  step;
    logic [POS_W:0]  sum;
    logic [POS_W:0]  nxt_pos;

    assign valid    = up ^ down;
    assign hold_inc = hold_cnt + HW'(1);
    assign pos_e    = {1'b0, height};

    // Fast step only while the held direction matches the latched one.
    always_comb begin
        step    = (state == P_FAST && down == dir_q) ? FAST_E : SLOW_E;
        sum     = pos_e + step;
        nxt_pos = '0;
        if (down)
            nxt_pos = (sum > MAX_E) ? MAX_E : sum;
        else
            nxt_pos = (pos_e < step) ? '0 : pos_e - step;
    end

    assign hit = ({1'b0, hori} >= X_LO) && ({1'b0, hori} < X_HI) &&
                 ({1'b0, vert} >= pos_e) && ({1'b0, vert} < pos_e + PH_E);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            height   <= POS_W'(CENTRE);
            state    <= P_IDLE;
            hold_cnt <= '0;
            dir_q    <= 1'b0;
            on       <= 1'b0;
        end else begin
            on <= hit;
            if (recenter) begin
                height   <= POS_W'(CENTRE);
                state    <= P_IDLE;
                hold_cnt <= '0;
            end else if (!start || !valid) begin
                state    <= P_IDLE;
                hold_cnt <= '0;
            end else if (tick) begin
                height <= nxt_pos[POS_W-1:0];
                case (state)
                    P_IDLE: begin
                        state    <= P_SLOW;
                        hold_cnt <= HW'(1);
                        dir_q    <= down;
                    end
                    P_SLOW: begin
                        if (down != dir_q) begin
                            hold_cnt <= HW'(1);
                            dir_q    <= down;
                        end else begin
                            hold_cnt <= hold_inc;
                            if (hold_inc == HW'(HOLD_TICKS))
                                state <= P_FAST;
                        end
                    end
                    P_FAST: begin
                        if (down != dir_q) begin
                            state    <= P_SLOW;
                            hold_cnt <= HW'(1);
                            dir_q    <= down;
                        end
                    end
                    default: state <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/pong_paddle_bank.sv
// N-paddle bank: shared motion tick divider, per-paddle channels, packed heights, OR'd pixel flag.
import pong_pkg::*;

module pong_paddle_bank #(
    parameter int NUM_PADDLES    = 2,
    parameter int POS_W          = POS_W_DEF,
    parameter int PADDLE_HEIGHT  = 48,
    parameter int PADDLE_WIDTH   = 8,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int PADDLE_X0      = 16,
    parameter int PADDLE_X_PITCH = 600,
    parameter int TICK_DIV       = 500000,
    parameter int STEP_SLOW      = 1,
    parameter int STEP_FAST      = 4,
    parameter int HOLD_TICKS     = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         recenter,
    input  logic [NUM_PADDLES-1:0]       paddle_up,
    input  logic [NUM_PADDLES-1:0]       paddle_down,
    input  logic [POS_W-1:0]             hori_cnt,
    input  logic [POS_W-1:0]             vert_cnt,
    output logic [NUM_PADDLES*POS_W-1:0] height,
    output logic [NUM_PADDLES-1:0]       on_vec,
    output logic                         on
);

    localparam int MAX_POS = SCREEN_HEIGHT - PADDLE_HEIGHT;
    localparam int CENTRE  = MAX_POS / 2;
    localparam int CW      = $clog2(TICK_DIV);
    localparam longint LAST_X_END = longint'(PADDLE_X0) +
        longint'(NUM_PADDLES - 1) * longint'(PADDLE_X_PITCH) + longint'(PADDLE_WIDTH);

    if (MAX_POS <= 0)                                 begin : g_chk_max  $error("MAX_POS must be positive"); end
    if (longint'(MAX_POS) >= (longint'(1) << POS_W))  begin : g_chk_fit  $error("MAX_POS must fit POS_W"); end
    if (STEP_SLOW < 1 || STEP_FAST < STEP_SLOW)       begin : g_chk_step $error("need STEP_FAST>=STEP_SLOW>=1"); end
    if (TICK_DIV < 2)                                 begin : g_chk_div  $error("TICK_DIV must be >= 2"); end
    if (HOLD_TICKS < 1)                               begin : g_chk_hold $error("HOLD_TICKS must be >= 1"); end
    if (LAST_X_END > (longint'(1) << POS_W))          begin : g_chk_x    $error("last paddle column exceeds POS_W"); end

    logic [CW-1:0]          tick_cnt;
    logic                   tick;
    logic [NUM_PADDLES-1:0] hit_vec;

    assign tick = start && (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tick_cnt <= '0;
        else if (!start || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
        pong_paddle_channel #(
            .POS_W         (POS_W),
            .PADDLE_HEIGHT (PADDLE_HEIGHT),
            .PADDLE_WIDTH  (PADDLE_WIDTH),
            .MAX_POS       (MAX_POS),
            .CENTRE        (CENTRE),
            .X_POS         (PADDLE_X0 + i * PADDLE_X_PITCH),
            .STEP_SLOW     (STEP_SLOW),
            .STEP_FAST     (STEP_FAST),
            .HOLD_TICKS    (HOLD_TICKS)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick),
            .start    (start),
            .recenter (recenter),
            .up       (paddle_up[i]),
            .down     (paddle_down[i]),
            .hori     (hori_cnt),
            .vert     (vert_cnt),
            .height   (height[i*POS_W +: POS_W]),
            .hit      (hit_vec[i]),
            .on       (on_vec[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) on <= 1'b0;
        else          on <= |hit_vec;
    end

endmodule

// File: tb/tb_pong_paddle_bank.sv
// Directed + random bench for pong_paddle_bank against a behavioural paddle model.
module tb_pong_paddle_bank;

    localparam int NP = 2, PW = 10, TD = 4, HT = 3;
    localparam int MAXP = 432, CEN = 216, PH = 48, PWID = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start, recenter;
    logic [NP-1:0]   paddle_up, paddle_down;
    logic [PW-1:0]   hori_cnt, vert_cnt;
    logic [NP*PW-1:0] height;
    logic [NP-1:0]   on_vec;
    logic            on;

    pong_paddle_bank #(.NUM_PADDLES(NP), .POS_W(PW), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .recenter(recenter),
        .paddle_up(paddle_up), .paddle_down(paddle_down),
        .hori_cnt(hori_cnt), .vert_cnt(vert_cnt),
        .height(height), .on_vec(on_vec), .on(on)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Model: speed mode 0=still, 1=slow, 2=fast; held = consecutive ticks in current direction.
    int mh[NP], mmode[NP], mheld[NP], mdir[NP];
    int mcnt;
    int mon_vec, mon;
    bit last_tick;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int hgt(input int i);
        return int'(height[i*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            mh[i] = CEN; mmode[i] = 0; mheld[i] = 0; mdir[i] = 0;
        end
        mcnt = 0; mon_vec = 0; mon = 0;
    endtask

    // One clock: advance the model from current inputs, then compare everything.
    task automatic cycle();
        int nv;
        bit tk;
        tk = start && (mcnt == TD - 1);
        nv = 0;
        for (int i = 0; i < NP; i++) begin
            int x, h, u, d, s;
            x = 16 + i * 600;
            h = int'(hori_cnt); u = int'(vert_cnt);
            if (h >= x && h < x + PWID && u >= mh[i] && u < mh[i] + PH) nv |= (1 << i);
            d = paddle_down[i];
            if (recenter) begin
                mh[i] = CEN; mmode[i] = 0; mheld[i] = 0;
            end else if (!start || !(paddle_up[i] ^ paddle_down[i])) begin
                mmode[i] = 0; mheld[i] = 0;
            end else if (tk) begin
                if (mmode[i] == 0 || d != mdir[i]) begin
                    s = 1; mmode[i] = 1; mheld[i] = 1; mdir[i] = d;
                end else if (mmode[i] == 1) begin
                    s = 1; mheld[i]++;
                    if (mheld[i] == HT) mmode[i] = 2;
                end else begin
                    s = 4;
                end
                if (d) mh[i] = (mh[i] + s > MAXP) ? MAXP : mh[i] + s;
                else   mh[i] = (mh[i] < s) ? 0 : mh[i] - s;
            end
        end
        mcnt = start ? (mcnt + 1) % TD : 0;
        last_tick = tk;
        @(posedge clk); #1;
        mon_vec = nv; mon = (nv != 0);
        check("height0", hgt(0), mh[0]);
        check("height1", hgt(1), mh[1]);
        check("on_vec", int'(on_vec), mon_vec);
        check("on", int'(on), mon);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int acc_exp[5];
        int got, hb;
        acc_exp = '{217, 218, 219, 223, 227};
        reset_n = 1'b0; start = 0; recenter = 0;
        paddle_up = '0; paddle_down = '0; hori_cnt = '0; vert_cnt = '0;
        model_reset();
        #23;
        check("rst_h0", hgt(0), 216);
        check("rst_h1", hgt(1), 216);
        check("rst_on", int'(on), 0);
        check("rst_on_vec", int'(on_vec), 0);
        @(posedge clk); #1; reset_n = 1'b1;

        // Frozen while start=0
        paddle_up = 2'b01;
        run(100);
        check("freeze_h0", hgt(0), 216);

        // Acceleration profile
        paddle_up = '0; paddle_down = 2'b01; start = 1;
        got = 0;
        for (int n = 0; n < 40 && got < 5; n++) begin
            cycle();
            if (last_tick) begin
                check("accel_h0", hgt(0), acc_exp[got]);
                got++;
            end
        end
        check("accel_ticks", got, 5);
        check("accel_h1", hgt(1), 216);

        // Clamp at both ends
        run(240);
        check("clamp_bottom", hgt(0), 432);
        run(8);
        check("clamp_bottom_hold", hgt(0), 432);
        paddle_down = '0; paddle_up = 2'b01;
        run(480);
        check("clamp_top", hgt(0), 0);

        // Conflict: both directions held -> no motion
        paddle_up = '0; paddle_down = 2'b01;
        run(40);
        hb = mh[0];
        paddle_up = 2'b01;
        run(12);
        check("conflict_hold", hgt(0), hb);

        // Reversal from fast drops back to a slow step
        paddle_up = '0;
        run(24);
        hb = mh[0];
        paddle_up = 2'b01; paddle_down = '0;
        got = 0;
        for (int n = 0; n < 8 && got == 0; n++) begin
            cycle();
            if (last_tick) got = 1;
        end
        check("reversal_tick", got, 1);
        check("reversal_step", hgt(0), hb - 1);

        // Recentre on a tick cycle, next tick is slow
        paddle_up = '0; paddle_down = 2'b11;
        run(20);
        for (int n = 0; n < 8 && mcnt != TD - 1; n++) cycle();
        recenter = 1;
        cycle();
        recenter = 0;
        check("recenter_h0", hgt(0), 216);
        check("recenter_h1", hgt(1), 216);
        got = 0;
        for (int n = 0; n < 8 && got == 0; n++) begin
            cycle();
            if (last_tick) got = 1;
        end
        check("post_rc_h0", hgt(0), 217);
        check("post_rc_h1", hgt(1), 217);

        // Render boundaries, heights frozen at centre
        start = 0; paddle_down = '0; recenter = 1;
        cycle();
        recenter = 0;
        hori_cnt = 16; vert_cnt = 216; cycle();
        check("render_in_vec", int'(on_vec), 1);
        check("render_in_on", int'(on), 1);
        vert_cnt = 264; cycle();
        check("render_vert_end", int'(on_vec), 0);
        vert_cnt = 263; cycle();
        check("render_vert_last", int'(on_vec), 1);
        hori_cnt = 24; vert_cnt = 216; cycle();
        check("render_hori_end", int'(on), 0);
        hori_cnt = 616; vert_cnt = PW'(hgt(1)); cycle();
        check("render_p1", int'(on_vec), 2);
        check("render_p1_on", int'(on), 1);

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            start     = ($urandom_range(0, 19) != 0);
            recenter  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) begin
                paddle_up   = NP'($urandom);
                paddle_down = NP'($urandom);
            end
            hori_cnt = ($urandom_range(0, 1) != 0) ? PW'($urandom_range(10, 30))
                                                   : PW'($urandom_range(610, 630));
            vert_cnt = PW'($urandom_range(0, 479));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
